// File: rtl/sum_of_squares_issue.sv
// sum_of_squares_issue: squares signed samples with a shift-add multiplier, accumulates a frame, issues it to sqrt_pipelined.
// Latency: SAMPLE_BITS+2 cycles per non-final sample; start fires SAMPLE_BITS+2 cycles after the final accept edge.
// Backpressure: in_ready is high only in IDLE (and low during reset); start is never suppressed.
// Optional feature: define SOS_SATURATE_EN to clamp the frame sum at all ones and report sat; otherwise the sum wraps.
module sum_of_squares_issue #(
  parameter int SAMPLE_BITS = 8,
  parameter int FRAME_LEN   = 4,
  parameter int INPUT_BITS  = 18
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SAMPLE_BITS-1:0] in_data,
  input  logic                   in_last,
  output logic                   start,
  output logic [INPUT_BITS-1:0]  radicand,
  output logic                   sat
);

  localparam int PW = 2 * SAMPLE_BITS;
  localparam int CW = $clog2(SAMPLE_BITS + 1);
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
`ifdef SOS_SATURATE_EN
  localparam int SW = ((INPUT_BITS > PW) ? INPUT_BITS : PW) + 1;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    ACC   = 2'd2,
    ISSUE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           mcand_q, mcand_d;
  logic [SAMPLE_BITS-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]           prod_q, prod_d;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic                    last_q, last_d;
  logic [INPUT_BITS-1:0]   acc_q, acc_d;
  logic [FW-1:0]           frame_cnt_q, frame_cnt_d;
  logic                    start_q, start_d;
  logic [INPUT_BITS-1:0]   radicand_q, radicand_d;
`ifdef SOS_SATURATE_EN
  logic                    sat_acc_q, sat_acc_d;
  logic                    sat_q, sat_d;
  logic [SW-1:0]           sum_wide;
`endif

  logic                    accept;
  logic                    mul_done;
  logic                    frame_done;
  logic [SAMPLE_BITS-1:0]  abs_data;
  logic [INPUT_BITS-1:0]   acc_next;
  logic                    sat_next;

  // Magnitude of the incoming sample; the most negative value maps to 2^(SAMPLE_BITS-1) without overflow.
  always_comb begin
    abs_data = in_data;
    if (in_data[SAMPLE_BITS-1]) begin
      abs_data = (~in_data) + SAMPLE_BITS'(1);
    end
  end

  assign accept     = in_valid && in_ready;
  assign mul_done   = (bit_cnt_q == CW'(SAMPLE_BITS - 1));
  assign frame_done = last_q || (frame_cnt_q == FW'(FRAME_LEN - 1));

  // Frame sum after adding the current square: clamped when saturation is built in, modulo 2^INPUT_BITS otherwise.
`ifdef SOS_SATURATE_EN
  always_comb begin
    sum_wide = SW'(acc_q) + SW'(prod_q);
    acc_next = sum_wide[INPUT_BITS-1:0];
    sat_next = sat_acc_q;
    if (|sum_wide[SW-1:INPUT_BITS]) begin
      acc_next = '1;
      sat_next = 1'b1;
    end
  end
`else
  always_comb begin
    acc_next = acc_q + INPUT_BITS'(prod_q);
    sat_next = 1'b0;
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one pass through MUL and ACC per sample, ISSUE once per frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = MUL;
      MUL:     if (mul_done) state_d = ACC;
      ACC:     state_d = frame_done ? ISSUE : IDLE;
      ISSUE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: ready only while idle and out of reset; issue outputs come straight from flops.
  always_comb begin
    in_ready = (state_q == IDLE) && !reset;
    start    = start_q;
    radicand = radicand_q;
`ifdef SOS_SATURATE_EN
    sat      = sat_q;
`else
    sat      = 1'b0;
`endif
  end

  // Datapath next values: sample capture, shift-add multiply, accumulate, issue and clear.
  always_comb begin
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    bit_cnt_d   = bit_cnt_q;
    last_d      = last_q;
    acc_d       = acc_q;
    frame_cnt_d = frame_cnt_q;
    start_d     = 1'b0;
    radicand_d  = radicand_q;
`ifdef SOS_SATURATE_EN
    sat_acc_d   = sat_acc_q;
    sat_d       = sat_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          mcand_d   = PW'(abs_data);
          mplier_d  = abs_data;
          prod_d    = '0;
          bit_cnt_d = '0;
          last_d    = in_last;
        end
      end
      MUL: begin
        if (mplier_q[0]) begin
          prod_d = prod_q + mcand_q;
        end
        mcand_d   = mcand_q << 1;
        mplier_d  = mplier_q >> 1;
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
      ACC: begin
        acc_d       = acc_next;
        frame_cnt_d = frame_cnt_q + FW'(1);
`ifdef SOS_SATURATE_EN
        sat_acc_d   = sat_next;
`endif
        // The issue values are registered here so they are valid during the ISSUE cycle.
        if (frame_done) begin
          start_d    = 1'b1;
          radicand_d = acc_next;
`ifdef SOS_SATURATE_EN
          sat_d      = sat_next;
`endif
        end
      end
      ISSUE: begin
        acc_d       = '0;
        frame_cnt_d = '0;
`ifdef SOS_SATURATE_EN
        sat_acc_d   = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any partial frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      bit_cnt_q   <= '0;
      last_q      <= 1'b0;
      acc_q       <= '0;
      frame_cnt_q <= '0;
      start_q     <= 1'b0;
      radicand_q  <= '0;
`ifdef SOS_SATURATE_EN
      sat_acc_q   <= 1'b0;
      sat_q       <= 1'b0;
`endif
    end else begin
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      bit_cnt_q   <= bit_cnt_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      frame_cnt_q <= frame_cnt_d;
      start_q     <= start_d;
      radicand_q  <= radicand_d;
`ifdef SOS_SATURATE_EN
      sat_acc_q   <= sat_acc_d;
      sat_q       <= sat_d;
`endif
    end
  end

endmodule

// File: doc/sum_of_squares_issue.md
Name: sum_of_squares_issue

Overview:
- Upstream feeder for sqrt_pipelined.
- Accepts a stream of signed samples over a valid/ready handshake and squares each one with a sequential shift-add multiplier.
- Accumulates the squares over a frame, then issues a one-cycle start pulse with the frame energy on radicand.
- Together with sqrt_pipelined this forms the vector-magnitude path: magnitude = sqrt(sum x_i^2).

Parameters:
- SAMPLE_BITS, 8, signed sample width, two's complement; minimum 2.
- FRAME_LEN, 4, samples per frame before auto-issue; minimum 1.
- INPUT_BITS, 18, radicand width; must match sqrt_pipelined INPUT_BITS; 2*SAMPLE_BITS+clog2(FRAME_LEN) guarantees no overflow.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  SAMPLE_BITS  signed sample.
- in_last  in  1  qualifies in_data as the final sample of a short frame.
- start  out  1  one-cycle issue pulse to sqrt_pipelined.start.
- radicand  out  INPUT_BITS  frame sum of squares to sqrt_pipelined.radicand.
- sat  out  1  frame accumulation saturated; valid while start=1.

Behaviour:
- Reset values (async, immediate): state=IDLE, in_ready=0 while reset is high, start=0, radicand=0, sat=0, accumulator=0, frame count=0, multiplier registers=0.
- FSM states: IDLE, MUL, ACC, ISSUE.
- IDLE:
  - in_ready=1 (combinational from state, gated low by reset).
  - Transfer occurs on in_valid&&in_ready at edge t.
  - On transfer: latch |in_data| as SAMPLE_BITS unsigned (-2^(SAMPLE_BITS-1) gives 2^(SAMPLE_BITS-1), no overflow), latch in_last, clear partial product, go to MUL.
- MUL:
  - in_ready=0.
  - Runs exactly SAMPLE_BITS cycles (t+1..t+SAMPLE_BITS).
  - Each cycle: add shifted multiplicand if the current multiplier LSB is 1, shift.
  - Product width is 2*SAMPLE_BITS.
- ACC (cycle t+SAMPLE_BITS+1):
  - acc = acc + square, zero-extended to INPUT_BITS; overflow handling per optional feature.
  - frame_cnt++.
  - If the latched in_last is set or frame_cnt was FRAME_LEN-1, go to ISSUE; otherwise go to IDLE.
  - in_last coinciding with the FRAME_LEN-th sample produces a single issue.
- ISSUE (cycle t+SAMPLE_BITS+2):
  - start=1 for exactly this cycle; radicand=acc and sat are driven registered in this cycle.
  - acc, frame_cnt and the sat accumulator clear at the end of the cycle; go to IDLE.
  - radicand holds its last issued value until the next ISSUE.
- Throughput and latency:
  - Non-last sample: SAMPLE_BITS+2 cycles.
  - Last sample: SAMPLE_BITS+3 cycles.
  - Start fires SAMPLE_BITS+2 cycles after the final accept edge.
- in_valid without in_ready is ignored; in_data is not sampled outside IDLE.
- in_last on a non-accepted cycle has no effect.
- FRAME_LEN=1: every sample issues.
- sqrt_pipelined needs no backpressure; start is never suppressed.
- Reset mid-frame or mid-MUL:
  - Partial frame is discarded and no start is emitted.
  - The next accepted sample begins a fresh frame.

Optional Feature:
- Macro: SOS_SATURATE_EN.
- Defined: an ACC sum exceeding 2^INPUT_BITS-1 clamps acc to all ones and sets sat for the frame; subsequent adds stay clamped; sat is reported with start.
- Undefined: acc wraps modulo 2^INPUT_BITS; sat is tied 0; no saturation logic is synthesized.

Test Plan:
- Basic frame (defaults): in_valid held, samples 3,-4,0,0 accepted at cycles 0,10,20,30 -> start=1 only in cycle 40, radicand=25, sat=0; in_ready low cycles 1-9, 11-19, 21-29, 31-40.
- Early termination: samples 5 then 12 with in_last=1, second accepted at cycle t -> start at t+10, radicand=169; next frame starts with acc=0 (sample 1 alone, in_last=1 -> radicand=1).
- Extreme value: four samples of -128 (defaults) -> radicand=65536, sat=0; also exercise the simultaneous case, in_last=1 on the 4th sample -> exactly one start pulse.
- Saturation: INPUT_BITS=16, four samples of -128 -> with SOS_SATURATE_EN radicand=65535, sat=1; without it radicand=0, sat=0.
- Handshake: in_valid toggled randomly with in_data changing every cycle -> only values present at in_ready&&in_valid edges are accumulated; compare against a reference sum over 100 frames.
- Reset mid-operation: assert reset in the 4th MUL cycle of the 3rd sample -> start stays 0, radicand=0, in_ready=0 during reset and 1 after release; next frame of 1,1,1,1 -> radicand=4.
